// File: rtl/mul_16bit_wallace.sv
// rtl/mul_16bit_wallace.sv - signed 16x16->32 radix-4 Booth / Wallace-tree multiplier
// MUL_WALLACE_PIPE_EN: defined -> 3-stage pipeline (LAT=3); undefined -> output stage only (LAT=1).
module mul_16bit_wallace #(
  parameter int DATA_WIDTH = 16,
  parameter int RES_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_num_x,
  input  logic [DATA_WIDTH-1:0] i_num_y,
  output logic                  o_end,
  output logic [RES_WIDTH-1:0]  o_res,
  output logic                  o_cry
);

`ifdef MUL_WALLACE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  // Sum over all rows of -2^(16+2j): replaces every row's sign extension.
  localparam logic [31:0] SIGN_COMP = 32'hAAAB_0000;

  logic [16:0]       x1;
  logic [16:0]       x2;
  logic [16:0]       y_ext;
  logic [2:0]        grp;
  logic              one;
  logic              two;
  logic [16:0]       mag;
  logic [16:0]       row;
  logic [7:0][16:0]  pp_d;
  logic [7:0]        neg_d;
  logic [7:0][16:0]  pp_s;
  logic [7:0]        neg_s;
  logic [8:0][31:0]  rows;
  logic [31:0]       a0, a1, a2, a3, a4, a5;
  logic [31:0]       b0, b1, b2, b3;
  logic [31:0]       c0, c1;
  logic [31:0]       tsum_d, tcy_d;
  logic [31:0]       tsum_s, tcy_s;
  logic [31:0]       res_d;
  logic              ovf_d;
  logic [31:0]       res_q;
  logic              ovf_q;
  logic [LAT-1:0]    vld_d;
  logic [LAT-1:0]    vld_q;

  assign x1    = {i_num_x[15], i_num_x};
  assign x2    = {i_num_x, 1'b0};
  assign y_ext = {i_num_y, 1'b0};

  // Booth digit from {y[2j+1], y[2j], y[2j-1]}; negative digits emit ~mag and a +1 in the tree.
  always_comb begin
    pp_d  = '0;
    neg_d = '0;
    grp   = '0;
    one   = 1'b0;
    two   = 1'b0;
    mag   = '0;
    row   = '0;
    for (int j = 0; j < 8; j++) begin
      grp      = y_ext[2*j +: 3];
      neg_d[j] = grp[2] & ~(grp[1] & grp[0]);
      one      = grp[1] ^ grp[0];
      two      = (grp == 3'b100) | (grp == 3'b011);
      mag      = one ? x1 : (two ? x2 : 17'd0);
      row      = neg_d[j] ? ~mag : mag;
      pp_d[j]  = {~row[16], row[15:0]};
    end
  end

  always_comb begin
    rows    = '0;
    rows[8] = SIGN_COMP;
    for (int j = 0; j < 8; j++) begin
      rows[j]        = {15'd0, pp_s[j]} << (2 * j);
      rows[8][2 * j] = neg_s[j];
    end
  end

  function automatic logic [63:0] csa(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    logic [31:0] s;
    logic [31:0] cy;
    s  = a ^ b ^ c;
    cy = ((a & b) | (a & c) | (b & c)) << 1;
    return {cy, s};
  endfunction

  // 9 rows -> 6 -> 4 -> 3 -> 2 through carry-save layers.
  assign {a1, a0}       = csa(rows[0], rows[1], rows[2]);
  assign {a3, a2}       = csa(rows[3], rows[4], rows[5]);
  assign {a5, a4}       = csa(rows[6], rows[7], rows[8]);
  assign {b1, b0}       = csa(a0, a1, a2);
  assign {b3, b2}       = csa(a3, a4, a5);
  assign {c1, c0}       = csa(b0, b1, b2);
  assign {tcy_d, tsum_d} = csa(c0, c1, b3);

  assign res_d = tsum_s + tcy_s;
  assign ovf_d = ~((&res_d[31:15]) | ~(|res_d[31:15]));

`ifdef MUL_WALLACE_PIPE_EN
  logic [7:0][16:0] pp_q;
  logic [7:0]       neg_q;
  logic [31:0]      tsum_q;
  logic [31:0]      tcy_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pp_q   <= '0;
      neg_q  <= '0;
      tsum_q <= '0;
      tcy_q  <= '0;
    end else begin
      pp_q   <= pp_d;
      neg_q  <= neg_d;
      tsum_q <= tsum_d;
      tcy_q  <= tcy_d;
    end
  end

  assign pp_s   = pp_q;
  assign neg_s  = neg_q;
  assign tsum_s = tsum_q;
  assign tcy_s  = tcy_q;
`else
  assign pp_s   = pp_d;
  assign neg_s  = neg_d;
  assign tsum_s = tsum_d;
  assign tcy_s  = tcy_d;
`endif

  always_comb begin
    vld_d    = '0;
    vld_d[0] = 1'b1;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= '0;
    end else begin
      res_q <= res_d;
      ovf_q <= ovf_d;
      vld_q <= vld_d;
    end
  end

  assign o_res = res_q;
  assign o_cry = ovf_q;
  assign o_end = vld_q[LAT-1];

endmodule

// File: tb/tb_mul_16bit_wallace.sv
// tb/tb_mul_16bit_wallace.sv - directed and random checks of mul_16bit_wallace against a signed-product model
module tb_mul_16bit_wallace;

`ifdef MUL_WALLACE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int NRAND = 1000;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] r;
    logic        c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        o_end;
  logic [31:0] o_res;
  logic        o_cry;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] exp_res [NRAND];
  logic        exp_cry [NRAND];
  vec_t        dir [9];

  always #5 clk = ~clk;

  mul_16bit_wallace dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_num_x (x),
    .i_num_y (y),
    .o_end   (o_end),
    .o_res   (o_res),
    .o_cry   (o_cry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ref_prod(input logic [15:0] a, input logic [15:0] b);
    return int'($signed(a)) * int'($signed(b));
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = ref_prod(a, b);
    return (p < -32768) || (p > 32767);
  endfunction

  initial begin
    dir = '{
      '{16'hFFFA, 16'hFFF9, 32'h0000_002A, 1'b0},
      '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 1'b1},
      '{16'h8000, 16'h8000, 32'h4000_0000, 1'b1},
      '{16'h8000, 16'hFFFF, 32'h0000_8000, 1'b1},
      '{16'h1234, 16'h0000, 32'h0000_0000, 1'b0},
      '{16'h0001, 16'hFFFF, 32'hFFFF_FFFF, 1'b0},
      '{16'h7FFF, 16'h8000, 32'hC000_8000, 1'b1},
      '{16'h00FF, 16'h0080, 32'h0000_7F80, 1'b0},
      '{16'h0100, 16'h0080, 32'h0000_8000, 1'b1}
    };

    // Reset held
    x = 16'hFFFA;
    y = 16'hFFF9;
    repeat (2) @(negedge clk);
    chk("rst_end", {31'd0, o_end}, 32'd0);
    chk("rst_res", o_res, 32'd0);
    chk("rst_cry", {31'd0, o_cry}, 32'd0);

    // Release: o_end after exactly LAT edges
    rst_n = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < LAT) chk("end_early", {31'd0, o_end}, 32'd0);
    end
    chk("rel_end", {31'd0, o_end}, 32'd1);
    chk("rel_res", o_res, 32'h0000_002A);
    chk("rel_cry", {31'd0, o_cry}, 32'd0);

    // Asynchronous reset mid-cycle
    x = 16'hFFFA;
    y = 16'h0005;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_end", {31'd0, o_end}, 32'd0);
    chk("async_res", o_res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < LAT) chk("end_early2", {31'd0, o_end}, 32'd0);
    end
    chk("rel2_end", {31'd0, o_end}, 32'd1);
    chk("rel2_res", o_res, 32'hFFFF_FFE2);
    chk("rel2_cry", {31'd0, o_cry}, 32'd0);

    // Directed corner operands
    for (int i = 0; i < 9; i++) begin
      x = dir[i].x;
      y = dir[i].y;
      repeat (LAT) @(posedge clk);
      @(negedge clk);
      chk("dir_res", o_res, dir[i].r);
      chk("dir_cry", {31'd0, o_cry}, {31'd0, dir[i].c});
    end

    // Back-to-back random operands, one per cycle
    for (int k = 0; k < NRAND + LAT; k++) begin
      if (k >= LAT) begin
        chk("rand_res", o_res, exp_res[k-LAT]);
        chk("rand_cry", {31'd0, o_cry}, {31'd0, exp_cry[k-LAT]});
        chk("rand_end", {31'd0, o_end}, 32'd1);
      end
      if (k < NRAND) begin
        x = 16'($urandom);
        y = 16'($urandom);
        if ($urandom_range(0, 7) == 0) x = 16'h8000;
        if ($urandom_range(0, 7) == 0) y = 16'($urandom_range(0, 3)) - 16'd2;
        exp_res[k] = 32'(ref_prod(x, y));
        exp_cry[k] = ref_ovf(x, y);
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
